// File: rtl/avalon_burst_master.sv
// Avalon-MM burst initiator: one command becomes one fixed-address read or write burst.
// Latency: bus activity starts the cycle after command accept; read data returns READ_LATENCY+1 cycles after each accepted beat.
// Backpressure: WaitRequest freezes the bus outputs and beat counter; write data waits on o_WData_Ready; read data has no backpressure.
module avalon_burst_master #(
  parameter int READ_LATENCY = 1,
  parameter int MAX_BURST    = 128
) (
  input  logic        i_Clk,
  input  logic        i_Rst_n,
  input  logic        i_Cmd_Valid,
  output logic        o_Cmd_Ready,
  input  logic        i_Cmd_Write,
  input  logic [29:0] i_Cmd_Addr,
  input  logic [3:0]  i_Cmd_ByteEn,
  input  logic [7:0]  i_Cmd_BurstCount,
  input  logic [31:0] i_WData,
  input  logic        i_WData_Valid,
  output logic        o_WData_Ready,
  output logic [31:0] o_RData,
  output logic        o_RData_Valid,
  output logic        o_Busy,
  output logic        o_Done,
  output logic [29:0] o_AV_Addr,
  output logic [3:0]  o_AV_ByteEn,
  output logic        o_AV_Read,
  input  logic [31:0] i_AV_ReadData,
  output logic        o_AV_Write,
  output logic [31:0] o_AV_WriteData,
  input  logic        i_AV_WaitRequest,
  output logic [7:0]  o_AV_BurstCount
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

  localparam logic [7:0] MAX_CNT = 8'(MAX_BURST);
  // Marks the oldest slot of the read-latency pipe (the one whose data is on the bus now).
  localparam logic [READ_LATENCY-1:0] PIPE_TOP = READ_LATENCY'(1) << (READ_LATENCY - 1);

  state_t                  state_q, state_d;
  logic [29:0]             addr_q, addr_d;
  logic [3:0]              byteen_q, byteen_d;
  logic [7:0]              bcnt_q, bcnt_d;
  logic [7:0]              remaining_q, remaining_d;
  logic [READ_LATENCY-1:0] pipe_q, pipe_d;
  logic [31:0]             rdata_q, rdata_d;
  logic                    rdata_vld_q, rdata_vld_d;
  logic                    done_q, done_d;

  logic                    cmd_fire;
  logic                    wr_beat;
  logic                    rd_beat;
  logic                    pipe_out;
  logic                    pipe_last;
  logic [7:0]              eff_cnt;

  // Command handshake and per-beat acceptance; write data passes straight through to the bus.
  assign o_Cmd_Ready    = (state_q == ST_IDLE);
  assign cmd_fire       = i_Cmd_Valid & o_Cmd_Ready;
  assign o_AV_Write     = (state_q == ST_WRITE) & i_WData_Valid;
  assign o_AV_WriteData = i_WData;
  assign o_WData_Ready  = (state_q == ST_WRITE) & ~i_AV_WaitRequest;
  assign o_AV_Read      = (state_q == ST_READ);
  assign wr_beat        = o_AV_Write & ~i_AV_WaitRequest;
  assign rd_beat        = o_AV_Read & ~i_AV_WaitRequest;

  // A slot leaving the pipe is the final beat when nothing younger is still in flight.
  assign pipe_out  = pipe_q[READ_LATENCY-1];
  assign pipe_last = pipe_out && ((pipe_q & ~PIPE_TOP) == '0);

  assign o_AV_Addr       = addr_q;
  assign o_AV_ByteEn     = byteen_q;
  assign o_AV_BurstCount = bcnt_q;
  assign o_RData         = rdata_q;
  assign o_RData_Valid   = rdata_vld_q;
  assign o_Busy          = (state_q != ST_IDLE);
  assign o_Done          = done_q;

  // Effective burst length: zero means one beat, oversize requests clamp to the maximum.
  always_comb begin
    eff_cnt = i_Cmd_BurstCount;
    if (i_Cmd_BurstCount == 8'd0) begin
      eff_cnt = 8'd1;
    end else if (i_Cmd_BurstCount > MAX_CNT) begin
      eff_cnt = MAX_CNT;
    end
  end

  // Burst sequencing: capture command, count accepted beats, finish on last write or last read return.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    byteen_d    = byteen_q;
    bcnt_d      = bcnt_q;
    remaining_d = remaining_q;
    done_d      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          addr_d      = i_Cmd_Addr;
          byteen_d    = i_Cmd_ByteEn;
          bcnt_d      = eff_cnt;
          remaining_d = eff_cnt;
          state_d     = i_Cmd_Write ? ST_WRITE : ST_READ;
        end
      end
      ST_WRITE: begin
        if (wr_beat) begin
          remaining_d = remaining_q - 8'd1;
          if (remaining_q == 8'd1) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      ST_READ: begin
        if (rd_beat) begin
          remaining_d = remaining_q - 8'd1;
          if (remaining_q == 8'd1) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (pipe_last) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Read return path: shift accept flags through the latency pipe and capture data as each flag exits.
  always_comb begin
    pipe_d      = (pipe_q << 1) | READ_LATENCY'(rd_beat);
    rdata_vld_d = pipe_out;
    rdata_d     = rdata_q;
    if (pipe_out) begin
      rdata_d = i_AV_ReadData;
    end
  end

  // State and datapath registers; reset aborts any burst in flight without a done pulse.
  always_ff @(posedge i_Clk or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      byteen_q    <= '0;
      bcnt_q      <= '0;
      remaining_q <= '0;
      pipe_q      <= '0;
      rdata_q     <= '0;
      rdata_vld_q <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      byteen_q    <= byteen_d;
      bcnt_q      <= bcnt_d;
      remaining_q <= remaining_d;
      pipe_q      <= pipe_d;
      rdata_q     <= rdata_d;
      rdata_vld_q <= rdata_vld_d;
      done_q      <= done_d;
    end
  end

endmodule

// File: tb/tb_avalon_burst_master.sv
// Bench for avalon_burst_master: directed bursts plus randomized bursts against a beat-level model.
// Timing: inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
// Slave model: random WaitRequest, fixed read latency, random read data; writer may starve.
module tb_avalon_burst_master;

  localparam int LAT  = 1;
  localparam int MAXB = 128;

  logic        i_Clk = 1'b0;
  logic        i_Rst_n;
  logic        i_Cmd_Valid;
  logic        o_Cmd_Ready;
  logic        i_Cmd_Write;
  logic [29:0] i_Cmd_Addr;
  logic [3:0]  i_Cmd_ByteEn;
  logic [7:0]  i_Cmd_BurstCount;
  logic [31:0] i_WData;
  logic        i_WData_Valid;
  logic        o_WData_Ready;
  logic [31:0] o_RData;
  logic        o_RData_Valid;
  logic        o_Busy;
  logic        o_Done;
  logic [29:0] o_AV_Addr;
  logic [3:0]  o_AV_ByteEn;
  logic        o_AV_Read;
  logic [31:0] i_AV_ReadData;
  logic        o_AV_Write;
  logic [31:0] o_AV_WriteData;
  logic        i_AV_WaitRequest;
  logic [7:0]  o_AV_BurstCount;

  avalon_burst_master #(.READ_LATENCY(LAT), .MAX_BURST(MAXB)) dut (
    .i_Clk            (i_Clk),
    .i_Rst_n          (i_Rst_n),
    .i_Cmd_Valid      (i_Cmd_Valid),
    .o_Cmd_Ready      (o_Cmd_Ready),
    .i_Cmd_Write      (i_Cmd_Write),
    .i_Cmd_Addr       (i_Cmd_Addr),
    .i_Cmd_ByteEn     (i_Cmd_ByteEn),
    .i_Cmd_BurstCount (i_Cmd_BurstCount),
    .i_WData          (i_WData),
    .i_WData_Valid    (i_WData_Valid),
    .o_WData_Ready    (o_WData_Ready),
    .o_RData          (o_RData),
    .o_RData_Valid    (o_RData_Valid),
    .o_Busy           (o_Busy),
    .o_Done           (o_Done),
    .o_AV_Addr        (o_AV_Addr),
    .o_AV_ByteEn      (o_AV_ByteEn),
    .o_AV_Read        (o_AV_Read),
    .i_AV_ReadData    (i_AV_ReadData),
    .o_AV_Write       (o_AV_Write),
    .o_AV_WriteData   (o_AV_WriteData),
    .i_AV_WaitRequest (i_AV_WaitRequest),
    .o_AV_BurstCount  (o_AV_BurstCount)
  );

  always #5 i_Clk = ~i_Clk;

  typedef struct {
    int          cyc;
    logic [31:0] dat;
  } beat_t;

  beat_t slave_q[$];  // read data the slave must present, keyed by cycle
  beat_t rexp_q[$];   // read data the master must return, keyed by cycle

  int cyc;
  int n_checks;
  int n_errors;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  // Advance one cycle and present any read data the slave owes this cycle.
  task automatic tick();
    @(posedge i_Clk);
    #1;
    cyc++;
    if (slave_q.size() > 0 && slave_q[0].cyc == cyc) begin
      i_AV_ReadData = slave_q[0].dat;
      void'(slave_q.pop_front());
    end else begin
      i_AV_ReadData = $urandom;
    end
  endtask

  task automatic run_cmd(input bit wr, input logic [29:0] addr, input logic [3:0] be,
                         input logic [7:0] cnt, input int wait_pct, input int starve_pct,
                         input int abort_after);
    int          eff;
    int          issued;
    int          done_cyc;
    int          guard;
    bit          wvld;
    bit          act;
    bit          acc;
    bit          rv_exp;
    bit          aborted;
    logic [31:0] wdat;
    beat_t       b;
    eff      = (cnt == 8'd0) ? 1 : ((int'(cnt) > MAXB) ? MAXB : int'(cnt));
    issued   = 0;
    done_cyc = -1;
    guard    = 0;
    wvld     = 1'b0;
    aborted  = 1'b0;
    wdat     = '0;

    i_Cmd_Valid      = 1'b1;
    i_Cmd_Write      = wr;
    i_Cmd_Addr       = addr;
    i_Cmd_ByteEn     = be;
    i_Cmd_BurstCount = cnt;
    i_WData_Valid    = 1'b0;
    i_AV_WaitRequest = ($urandom_range(0, 99) < wait_pct);
    @(negedge i_Clk);
    check("cmd_ready_idle", 32'(o_Cmd_Ready), 32'(1));
    check("idle_no_bus", 32'({o_AV_Read, o_AV_Write}), 32'(0));
    tick();

    while (guard < 3000) begin
      i_AV_WaitRequest = ($urandom_range(0, 99) < wait_pct);
      if (!wvld && wr) begin
        wvld = ($urandom_range(0, 99) >= starve_pct);
        wdat = $urandom;
      end
      i_WData_Valid    = wvld;
      i_WData          = wdat;
      i_Cmd_Valid      = (cyc != done_cyc) && ($urandom_range(0, 1) == 1);
      i_Cmd_Write      = 1'($urandom);
      i_Cmd_Addr       = 30'($urandom);
      i_Cmd_ByteEn     = 4'($urandom);
      i_Cmd_BurstCount = 8'($urandom);
      @(negedge i_Clk);

      check("busy", 32'(o_Busy), 32'(cyc != done_cyc));
      check("cmd_ready", 32'(o_Cmd_Ready), 32'(cyc == done_cyc));
      if (cyc != done_cyc) begin
        check("av_addr", 32'(o_AV_Addr), 32'(addr));
        check("av_byteen", 32'(o_AV_ByteEn), 32'(be));
        check("av_burstcount", 32'(o_AV_BurstCount), 32'(eff));
      end
      act = (issued < eff);
      check("av_read", 32'(o_AV_Read), 32'(!wr && act));
      check("av_write", 32'(o_AV_Write), 32'(wr && act && wvld));
      check("wdata_ready", 32'(o_WData_Ready), 32'(wr && act && !i_AV_WaitRequest));
      if (wr && act && wvld) begin
        check("av_writedata", o_AV_WriteData, wdat);
      end

      acc = act && !i_AV_WaitRequest && (!wr || wvld);
      if (acc) begin
        issued++;
        if (wr) begin
          wvld = 1'b0;
        end else begin
          b.dat = $urandom;
          b.cyc = cyc + LAT;
          slave_q.push_back(b);
          b.cyc = cyc + LAT + 1;
          rexp_q.push_back(b);
        end
        if (issued == eff) begin
          done_cyc = wr ? cyc + 1 : cyc + LAT + 1;
        end
      end

      rv_exp = (rexp_q.size() > 0) && (rexp_q[0].cyc == cyc);
      check("rdata_valid", 32'(o_RData_Valid), 32'(rv_exp));
      if (rv_exp) begin
        b = rexp_q.pop_front();
        check("rdata", o_RData, b.dat);
      end
      check("done", 32'(o_Done), 32'(cyc == done_cyc));

      if (cyc == done_cyc) begin
        break;
      end

      if (abort_after > 0 && issued == abort_after) begin
        aborted     = 1'b1;
        i_Cmd_Valid = 1'b0;
        tick();
        i_Rst_n = 1'b0;
        @(negedge i_Clk);
        check("abort_read", 32'(o_AV_Read), 32'(0));
        check("abort_rvalid", 32'(o_RData_Valid), 32'(0));
        check("abort_done", 32'(o_Done), 32'(0));
        check("abort_cmd_ready", 32'(o_Cmd_Ready), 32'(1));
        check("abort_burstcount", 32'(o_AV_BurstCount), 32'(0));
        slave_q.delete();
        rexp_q.delete();
        tick();
        i_Rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
          @(negedge i_Clk);
          check("post_abort_done", 32'(o_Done), 32'(0));
          check("post_abort_rvalid", 32'(o_RData_Valid), 32'(0));
          check("post_abort_read", 32'(o_AV_Read), 32'(0));
          tick();
        end
        break;
      end

      guard++;
      tick();
    end

    if (guard >= 3000) begin
      check("timeout_beats", 32'(issued), 32'(eff));
    end
    i_Cmd_Valid   = 1'b0;
    i_WData_Valid = 1'b0;
    if (!aborted) begin
      check("beat_count", 32'(issued), 32'(eff));
      tick();
    end
  endtask

  initial begin
    n_checks         = 0;
    n_errors         = 0;
    cyc              = 0;
    i_Rst_n          = 1'b0;
    i_Cmd_Valid      = 1'b0;
    i_Cmd_Write      = 1'b0;
    i_Cmd_Addr       = '0;
    i_Cmd_ByteEn     = '0;
    i_Cmd_BurstCount = '0;
    i_WData          = '0;
    i_WData_Valid    = 1'b0;
    i_AV_ReadData    = '0;
    i_AV_WaitRequest = 1'b0;

    repeat (2) @(posedge i_Clk);
    @(negedge i_Clk);
    check("rst_cmd_ready", 32'(o_Cmd_Ready), 32'(1));
    check("rst_busy", 32'(o_Busy), 32'(0));
    check("rst_done", 32'(o_Done), 32'(0));
    check("rst_rvalid", 32'(o_RData_Valid), 32'(0));
    check("rst_rdata", o_RData, 32'(0));
    check("rst_addr", 32'(o_AV_Addr), 32'(0));
    check("rst_byteen", 32'(o_AV_ByteEn), 32'(0));
    check("rst_burstcount", 32'(o_AV_BurstCount), 32'(0));
    check("rst_bus", 32'({o_AV_Read, o_AV_Write}), 32'(0));
    tick();
    i_Rst_n = 1'b1;
    tick();

    run_cmd(1'b1, 30'h3,  4'hF, 8'd4,   0,  0,  0);   // clean 4-beat write
    run_cmd(1'b0, 30'h0,  4'hF, 8'd3,   0,  0,  0);   // clean 3-beat read
    run_cmd(1'b1, 30'h5,  4'h3, 8'd3,   40, 0,  0);   // write with wait states
    run_cmd(1'b1, 30'h7,  4'hF, 8'd4,   0,  60, 0);   // write with starved data
    run_cmd(1'b1, 30'h9,  4'hF, 8'd0,   0,  0,  0);   // zero count means one beat
    run_cmd(1'b0, 30'h10, 4'hF, 8'd200, 10, 0,  0);   // clamp to MAX_BURST
    run_cmd(1'b1, 30'h11, 4'hC, 8'd255, 0,  10, 0);   // write clamp
    run_cmd(1'b0, 30'h20, 4'hF, 8'd4,   0,  0,  2);   // reset mid-burst
    run_cmd(1'b0, 30'h21, 4'h1, 8'd4,   30, 0,  0);   // clean run after abort

    for (int i = 0; i < 30; i++) begin
      run_cmd(1'($urandom), 30'($urandom), 4'($urandom),
              ($urandom_range(0, 7) == 0) ? 8'($urandom_range(129, 255)) : 8'($urandom_range(0, 16)),
              int'($urandom_range(0, 50)), int'($urandom_range(0, 50)), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
